// File: rtl/barrel_fetch_sched.sv
// barrel_fetch_sched: fetch stage for the barrel RISC-V core.
// Keeps one PC per hardware thread. A round-robin scheduler picks the next
// enabled thread. A combinational instruction memory is read in the same
// cycle, and a registered fetch packet is presented to decode.
// Branch redirects from execute either bypass into the current fetch or
// update the redirected thread's PC. They also squash a stale packet.
// Optional build macro: FETCH_PERF_CNT_EN adds per-thread fetch counters
// on the fetch_cnt output.
module barrel_fetch_sched #(
  parameter int                         DATA_WIDTH       = 32,
  parameter int                         ADDRESS_WIDTH    = 32,
  parameter int                         NUM_THREADS      = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC         = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   THREAD_PC_STRIDE = 'h400,
  localparam int                        BITS_THREADS     = $clog2(NUM_THREADS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_THREADS-1:0]    thread_en,
  input  logic                      stall_d,
  input  logic                      pc_src_e,
  input  logic [BITS_THREADS-1:0]   tid_e,
  input  logic [ADDRESS_WIDTH-1:0]  pc_target_e,
  output logic                      imem_en,
  output logic [ADDRESS_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0]     imem_instr,
  output logic                      valid_f,
  output logic [ADDRESS_WIDTH-1:0]  pc_f,
  output logic [ADDRESS_WIDTH-1:0]  pc_plus4_f,
  output logic [DATA_WIDTH-1:0]     instr_f,
  output logic [BITS_THREADS-1:0]   tid_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [NUM_THREADS*32-1:0] fetch_cnt
`endif
);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [BITS_THREADS-1:0]  last_tid_q;
  logic [BITS_THREADS-1:0]  sel_tid;
  logic                     valid_f_q, valid_f_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_plus4_f_q;
  logic [DATA_WIDTH-1:0]    instr_f_q;
  logic [BITS_THREADS-1:0]  tid_f_q;
  logic [ADDRESS_WIDTH-1:0] tgt;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     bypass;
  logic                     fetch;
  logic                     squash;

  // Round-robin pick: first enabled thread after the last issued one, with wrap
  always_comb begin
    int  idx;
    logic found;
    sel_tid = last_tid_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx = (int'(last_tid_q) + k) % NUM_THREADS;
      if (!found && thread_en[idx]) begin
        sel_tid = BITS_THREADS'(idx);
        found   = 1'b1;
      end
    end
  end

  assign imem_en = |thread_en;
  assign tgt     = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
  // A redirect of the thread being fetched right now goes straight to memory
  assign bypass  = pc_src_e && (tid_e == sel_tid);
  assign fetch   = !stall_d && imem_en;
  // The packet held in the fetch register belongs to the redirected thread
  assign squash  = pc_src_e && valid_f_q && (tid_f_q == tid_e);

  // Fetch address: zero when idle, redirect target when bypassed, else the thread PC
  always_comb begin
    imem_addr = '0;
    if (imem_en) imem_addr = bypass ? tgt : pc_q[sel_tid];
  end

  assign next_pc = imem_addr + ADDRESS_WIDTH'(4);

  // PC array next state: advance the fetched thread, and apply redirects that did not bypass
  always_comb begin
    pc_d = pc_q;
    if (fetch) pc_d[sel_tid] = next_pc;
    if (pc_src_e && !(fetch && (sel_tid == tid_e))) pc_d[tid_e] = tgt;
  end

  // Packet valid: a new load wins, an unstalled idle cycle clears, and a squash clears under stall
  always_comb begin
    valid_f_d = valid_f_q;
    if (fetch)        valid_f_d = 1'b1;
    else if (!stall_d) valid_f_d = 1'b0;
    else if (squash)  valid_f_d = 1'b0;
  end

  // Scheduler, PC array and fetch packet registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++)
        pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * THREAD_PC_STRIDE;
      last_tid_q   <= BITS_THREADS'(NUM_THREADS - 1);
      valid_f_q    <= 1'b0;
      pc_f_q       <= '0;
      pc_plus4_f_q <= '0;
      instr_f_q    <= '0;
      tid_f_q      <= '0;
    end else begin
      pc_q      <= pc_d;
      valid_f_q <= valid_f_d;
      if (fetch) begin
        last_tid_q   <= sel_tid;
        pc_f_q       <= imem_addr;
        pc_plus4_f_q <= next_pc;
        instr_f_q    <= imem_instr;
        tid_f_q      <= sel_tid;
      end
    end
  end

  assign valid_f    = valid_f_q;
  assign pc_f       = pc_f_q;
  assign pc_plus4_f = pc_plus4_f_q;
  assign instr_f    = instr_f_q;
  assign tid_f      = tid_f_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q [NUM_THREADS];
  logic [31:0] cnt_d [NUM_THREADS];

  // Per-thread count: +1 on a packet load, then -1 on a squash if still nonzero
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (fetch && (sel_tid == BITS_THREADS'(i))) cnt_d[i] = cnt_d[i] + 32'd1;
      if (squash && (tid_f_q == BITS_THREADS'(i)) && (cnt_d[i] != 32'd0))
        cnt_d[i] = cnt_d[i] - 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_cnt_out
    assign fetch_cnt[32*gi +: 32] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_barrel_fetch_sched.sv
// Testbench for barrel_fetch_sched. A behavioural model of the thread
// scheduler and packet register is checked on every cycle. Directed
// literal checks pin the model.
module tb_barrel_fetch_sched;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BT = 2;
  localparam logic [31:0] IMASK = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  thread_en;
  logic          stall_d;
  logic          pc_src_e;
  logic [BT-1:0] tid_e;
  logic [AW-1:0] pc_target_e;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr;
  logic          valid_f;
  logic [AW-1:0] pc_f, pc_plus4_f;
  logic [DW-1:0] instr_f;
  logic [BT-1:0] tid_f;
`ifdef FETCH_PERF_CNT_EN
  logic [N*32-1:0] fetch_cnt;
`endif

  always #5 clk = ~clk;

  // Instruction memory contents are a simple function of the address
  assign imem_instr = imem_addr ^ IMASK;

  barrel_fetch_sched dut (
    .clk(clk), .rst(rst), .thread_en(thread_en), .stall_d(stall_d),
    .pc_src_e(pc_src_e), .tid_e(tid_e), .pc_target_e(pc_target_e),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .valid_f(valid_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .instr_f(instr_f), .tid_f(tid_f)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_pc [N];
  int          m_last;
  bit          m_valid;
  logic [31:0] m_pcf, m_pc4, m_instr;
  int          m_tid;
  logic [31:0] m_cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pc[i]  = 32'h400 * i;
      m_cnt[i] = 0;
    end
    m_last = N - 1;
    m_valid = 0; m_pcf = 0; m_pc4 = 0; m_instr = 0; m_tid = 0;
  endtask

  task automatic check_regs();
    chk("valid_f", 64'(valid_f), 64'(m_valid));
    chk("pc_f", 64'(pc_f), 64'(m_pcf));
    chk("pc_plus4_f", 64'(pc_plus4_f), 64'(m_pc4));
    chk("instr_f", 64'(instr_f), 64'(m_instr));
    chk("tid_f", 64'(tid_f), 64'(m_tid));
`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < N; i++)
      chk("fetch_cnt", 64'(fetch_cnt[32*i +: 32]), 64'(m_cnt[i]));
`endif
  endtask

  // One cycle: drive inputs, check the combinational fetch, advance the model,
  // then check the registered packet after the edge.
  task automatic step(input logic [N-1:0] en, input logic st, input logic src,
                      input logic [BT-1:0] tid, input logic [31:0] target);
    int   sel;
    bit   any, fetch, squash;
    logic [31:0] tgt, addr;
    @(negedge clk);
    thread_en = en; stall_d = st; pc_src_e = src; tid_e = tid; pc_target_e = target;
    #1;
    any = (en != 0);
    sel = m_last;
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (m_last + k) % N;
      if (en[t]) begin sel = t; break; end
    end
    tgt = target & ~32'h3;
    if (!any) addr = 0;
    else if (src && int'(tid) == sel) addr = tgt;
    else addr = m_pc[sel];
    chk("imem_en", 64'(imem_en), 64'(any));
    chk("imem_addr", 64'(imem_addr), 64'(addr));
    fetch  = !st && any;
    squash = src && m_valid && (m_tid == int'(tid));
    if (fetch) begin
      m_cnt[sel] = m_cnt[sel] + 1;
    end
    if (squash && m_cnt[m_tid] != 0) m_cnt[m_tid] = m_cnt[m_tid] - 1;
    if (fetch) begin
      m_pcf = addr; m_pc4 = addr + 4; m_instr = addr ^ IMASK;
      m_tid = sel; m_valid = 1; m_pc[sel] = addr + 4; m_last = sel;
    end else if (!st || squash) begin
      m_valid = 0;
    end
    if (src && !(fetch && int'(tid) == sel)) m_pc[tid] = tgt;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    logic [31:0] exp_pc [8];
    int          exp_alt [4];
    bit          seen;
    exp_pc = '{32'h0, 32'h400, 32'h800, 32'hC00, 32'h4, 32'h404, 32'h804, 32'hC04};
    exp_alt = '{0, 2, 0, 2};
    rst = 1'b0; thread_en = '0; stall_d = 0; pc_src_e = 0; tid_e = 0; pc_target_e = 0;
    model_reset();
    #1 rst = 1'b1;
    #2;  // before any clock edge: reset is asynchronous
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Round robin over all four threads from reset
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 0, 0, 0, 0);
      chk("seq_pc", 64'(pc_f), 64'(exp_pc[k]));
      chk("seq_tid", 64'(tid_f), 64'(k % 4));
      chk("seq_valid", 64'(valid_f), 64'd1);
    end
`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < N; i++) chk("cnt_after8", 64'(fetch_cnt[32*i +: 32]), 64'd2);
`endif

    // Bypassed redirect of the selected thread
    step(4'b1111, 0, 0, 0, 0);                 // thread 0
    step(4'b1111, 0, 1, 2'd1, 32'h1003);       // thread 1 redirected
    chk("bypass_pc", 64'(pc_f), 64'h1000);
    chk("bypass_tid", 64'(tid_f), 64'd1);
    for (int k = 0; k < 4; k++) step(4'b1111, 0, 0, 0, 0);
    chk("after_bypass_pc", 64'(pc_f), 64'h1004);

    // Squash a valid thread-2 packet while stalled
    step(4'b1111, 0, 0, 0, 0);
    chk("pre_squash_tid", 64'(tid_f), 64'd2);
    step(4'b1111, 1, 1, 2'd2, 32'h2000);
    chk("squash_valid", 64'(valid_f), 64'd0);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step(4'b1111, 0, 0, 0, 0);
      if (tid_f == 2'd2) seen = 1;
    end
    chk("thread2_seen", 64'(seen), 64'd1);
    chk("thread2_target", 64'(pc_f), 64'h2000);

    // Three stalled cycles mid-stream
    for (int k = 0; k < 3; k++) step(4'b1111, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(4'b1111, 0, 0, 0, 0);

    // Two enabled threads alternate, then all disabled, then re-enabled
    for (int k = 0; k < 4; k++) begin
      step(4'b0101, 0, 0, 0, 0);
      chk("alt_tid", 64'(tid_f), 64'(exp_alt[k]));
    end
    step(4'b0000, 0, 0, 0, 0);
    chk("idle_valid", 64'(valid_f), 64'd0);
    chk("idle_imem_en", 64'(imem_en), 64'd0);
    for (int k = 0; k < 4; k++) step(4'b1111, 0, 0, 0, 0);

    // Single enabled thread issues back to back
    for (int k = 0; k < 3; k++) begin
      step(4'b0010, 0, 0, 0, 0);
      chk("single_tid", 64'(tid_f), 64'd1);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] en;
      en = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      step(en, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/barrel_fetch_sched.md
Name: barrel_fetch_sched

Overview:
- Next-generation fetch stage for the barrel RISC-V core.
- Holds one PC per hardware thread and picks the next thread with a round-robin scheduler that skips disabled threads.
- Accepts branch redirects from execute and squashes a stale fetched instruction of the redirected thread.
- Drives a combinational instruction memory and presents a registered fetch packet to decode, with stall support.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDRESS_WIDTH, 32, PC/address width.
- NUM_THREADS, 4, hardware thread count (>=2); BITS_THREADS = $clog2(NUM_THREADS).
- RESET_PC, 0, reset PC of thread 0.
- THREAD_PC_STRIDE, 'h400, reset PC of thread i = RESET_PC + i*THREAD_PC_STRIDE (mod 2^ADDRESS_WIDTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- thread_en  in  NUM_THREADS  per-thread fetch enable.
- stall_d  in  1  decode not ready; hold fetch packet and scheduler.
- pc_src_e  in  1  redirect valid from execute.
- tid_e  in  BITS_THREADS  thread being redirected.
- pc_target_e  in  ADDRESS_WIDTH  redirect target.
- imem_en  out  1  a thread is selected this cycle.
- imem_addr  out  ADDRESS_WIDTH  fetch address (combinational).
- imem_instr  in  DATA_WIDTH  instruction at imem_addr, same cycle.
- valid_f  out  1  fetch packet valid.
- pc_f, pc_plus4_f  out  ADDRESS_WIDTH  PC of the packet, and PC+4.
- instr_f  out  DATA_WIDTH  fetched instruction.
- tid_f  out  BITS_THREADS  owning thread.

Behaviour:
- Reset, asynchronous:
  - pc[i] = RESET_PC + i*THREAD_PC_STRIDE.
  - last_tid = NUM_THREADS-1, so the first pick is thread 0.
  - valid_f=0; pc_f, pc_plus4_f, instr_f, tid_f = 0.
- Selection (combinational):
  - sel_tid = first enabled thread scanning last_tid+1, last_tid+2, … with wrap mod NUM_THREADS.
  - imem_en = |thread_en.
  - If no thread is enabled, imem_addr = 0.
- Redirect alignment: tgt = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00}; low bits are always forced to zero.
- Fetch address (bypass):
  - imem_addr = tgt if pc_src_e && tid_e==sel_tid.
  - Otherwise imem_addr = pc[sel_tid].
- Cycle update when !stall_d and imem_en:
  - pc_f <= imem_addr.
  - pc_plus4_f <= imem_addr+4, wrapping mod 2^ADDRESS_WIDTH.
  - instr_f <= imem_instr; tid_f <= sel_tid; valid_f <= 1.
  - pc[sel_tid] <= imem_addr+4.
  - last_tid <= sel_tid.
- When !stall_d and !imem_en: valid_f <= 0; everything else holds.
- When stall_d: packet registers, valid_f, last_tid and the selected PC hold, and no PC increments.
- Redirects while stalled or for an unselected thread: if pc_src_e and tid_e is not fetched this cycle, pc[tid_e] <= tgt. This applies regardless of stall_d and of thread_en[tid_e].
- Squash:
  - If pc_src_e && valid_f && tid_f==tid_e, then valid_f <= 0 next cycle, even under stall_d.
  - The squash takes priority over packet hold.
  - If the same edge also loads a new packet, the new packet wins and valid_f=1 (its tid != tid_e unless bypassed, and a bypassed packet is correct).
- Dropping thread_en[i] mid-run:
  - Thread i is skipped from the next selection onward and its PC is retained.
  - A packet already issued for thread i stays valid.
- Single enabled thread: it is selected every cycle (back-to-back issue).
- Only one redirect per cycle, so there are no write conflicts on the PC array.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add output fetch_cnt NUM_THREADS*32:
  - One 32-bit counter per thread, thread i at bits [32*i+31:32*i].
  - Counter increments on every packet load for that thread (!stall_d && imem_en).
  - Decrements by 1 when that thread's valid packet is squashed, never below 0.
  - Wraps at 2^32; reset to 0.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with thread_en=4'b1111, imem_instr = address, then run 8 cycles -> tid_f 0,1,2,3,0,1,2,3. pc_f sequence 0x0,0x400,0x800,0xC00,0x4,0x404,0x804,0xC04. valid_f=1 from cycle 1.
- thread_en=4'b0101 -> tid_f alternates 0,2,0,2. Then set 4'b0000 -> valid_f=0 next cycle and imem_en=0. Re-enable -> resumes at the retained PCs.
- stall_d high 3 cycles mid-stream -> pc_f, instr_f and tid_f frozen. On release, fetch continues with the next thread and no PC is skipped.
- pc_src_e=1, tid_e=1, pc_target_e=0x1003 while thread 1 is selected -> imem_addr=0x1000, pc_f=0x1000, next pc[1]=0x1004.
- Packet tid_f=2 valid, redirect tid_e=2 with stall_d=1 -> valid_f=0 next cycle. pc[2]=target. Thread 2's next fetch is at the target.
- With FETCH_PERF_CNT_EN: 8 unstalled cycles with 4 threads -> each counter = 2. A squash of thread 2 -> counter 2 = 1.
